// File: rtl/scan_seq_pkg.sv
// Shared definitions for the scan sequencer: state encoding and default sizing.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package scan_seq_pkg;

  localparam int SWEEP_W_DEF        = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SCAN   = 3'd1;
  localparam state_t ST_DRAIN  = 3'd2;
  localparam state_t ST_FINISH = 3'd3;
  localparam state_t ST_ERROR  = 3'd4;

endpackage

// File: rtl/scan_watchdog.sv
// Stall watchdog: counts enabled cycles without a kick, flags when TIMEOUT_CYCLES is reached.
// Latency: timeout is combinational from the count; it fires in the TIMEOUT_CYCLES-th quiet cycle.
// Backpressure: none. Only built when SCAN_SEQ_WATCHDOG_EN is defined.
`ifdef SCAN_SEQ_WATCHDOG_EN
module scan_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic kick,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // A kick or an explicit clear restarts the count; outside the watched states it rests at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || kick || !en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = en && !kick && !clear && (cnt == LAST);

endmodule
`endif

// File: rtl/scan_sequencer.sv
// Runs the stepper scan controller for exactly N L->R->L sweeps, counting sweeps on dir falls.
// Latency: run rises the cycle after accept; dir edges act one cycle late; done one cycle after FINISH.
// Backpressure: cmd_ready only in IDLE. Optional stall watchdog under SCAN_SEQ_WATCHDOG_EN.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int SWEEP_W        = SWEEP_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [SWEEP_W-1:0] cmd_sweeps,
  output logic               cmd_ready,
  input  logic               abort,
  input  logic               dir_in,
  input  logic               step_in,
  output logic               run,
  output logic               busy,
  output logic               sweep_pulse,
  output logic [SWEEP_W-1:0] sweeps_done,
  output logic               done,
  output logic               aborted,
  output logic               error,
  input  logic               err_clear
);

  localparam logic [SWEEP_W-1:0] ONE = SWEEP_W'(1);

  state_t             state;
  logic               dir_d;
  logic [SWEEP_W-1:0] remaining;
  logic [SWEEP_W-1:0] sd_inc;
  logic               rise;
  logic               fall;
  logic               accept;
  logic               timeout;

  assign rise      = dir_in & ~dir_d;
  assign fall      = ~dir_in & dir_d;
  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state == ST_SCAN) || (state == ST_DRAIN) || (state == ST_FINISH);
  assign sd_inc    = (&sweeps_done) ? sweeps_done : sweeps_done + 1'b1;

`ifdef SCAN_SEQ_WATCHDOG_EN
  scan_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .en     ((state == ST_SCAN) || (state == ST_DRAIN)),
    .kick   (step_in),
    .timeout(timeout)
  );

  // Sticky stall flag; only err_clear while parked in ERROR releases it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if (timeout) begin
      error <= 1'b1;
    end else if ((state == ST_ERROR) && err_clear) begin
      error <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_inputs;
  assign unused_inputs = step_in ^ err_clear;
  assign timeout       = 1'b0;
  assign error         = 1'b0;
`endif

  // Job FSM: run is dropped on the last rise (or on abort) so the carriage parks at the left end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      dir_d       <= 1'b0;
      remaining   <= '0;
      sweeps_done <= '0;
      run         <= 1'b0;
      aborted     <= 1'b0;
      sweep_pulse <= 1'b0;
      done        <= 1'b0;
    end else begin
      dir_d       <= dir_in;
      sweep_pulse <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sweeps_done <= '0;
            aborted     <= 1'b0;
            remaining   <= cmd_sweeps;
            if (cmd_sweeps == '0) begin
              state <= ST_FINISH;
            end else begin
              run   <= 1'b1;
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (timeout) begin
            run   <= 1'b0;
            state <= ST_ERROR;
          end else begin
            if (fall) begin
              remaining   <= remaining - 1'b1;
              sweeps_done <= sd_inc;
              sweep_pulse <= 1'b1;
            end
            // abort coinciding with the last rise is a single drop of run
            if (abort || (rise && (remaining == ONE))) begin
              run   <= 1'b0;
              state <= ST_DRAIN;
              if (abort) begin
                aborted <= 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (timeout) begin
            state <= ST_ERROR;
          end else if (fall) begin
            sweeps_done <= sd_inc;
            sweep_pulse <= 1'b1;
            state       <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
`ifdef SCAN_SEQ_WATCHDOG_EN
        ST_ERROR: begin
          if (err_clear) begin
            state <= ST_IDLE;
          end
        end
`endif
        default: begin
          run   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer driving a behavioural scan controller (CLK_DIVIDER = 20).
// Table of jobs run through a loop, then hand-written corner-case sequences.
// Watchdog checks follow SCAN_SEQ_WATCHDOG_EN (TIMEOUT_CYCLES = 100).
module tb_scan_sequencer;

  localparam int SW      = 8;
  localparam int CLK_DIV = 20;
  localparam int SPAN    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [SW-1:0] cmd_sweeps = '0;
  logic          cmd_ready;
  logic          abort = 1'b0;
  logic          dir_in = 1'b0;
  logic          step_in = 1'b0;
  logic          run;
  logic          busy;
  logic          sweep_pulse;
  logic [SW-1:0] sweeps_done;
  logic          done;
  logic          aborted;
  logic          error;
  logic          err_clear = 1'b0;

  int total = 0;
  int bad = 0;

  scan_sequencer #(
    .SWEEP_W(SW),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_sweeps(cmd_sweeps),
    .cmd_ready(cmd_ready), .abort(abort), .dir_in(dir_in), .step_in(step_in),
    .run(run), .busy(busy), .sweep_pulse(sweep_pulse), .sweeps_done(sweeps_done),
    .done(done), .aborted(aborted), .error(error), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  // Behavioural scan controller: updates on the falling edge so the DUT samples stable values.
  int pos = 0;
  int div = 0;
  bit moving = 0;
  bit freeze = 0;
  always @(negedge clk) begin
    step_in = 1'b0;
    if (!freeze) begin
      if (!moving) begin
        if (run) begin
          moving = 1;
          div = 0;
        end
      end else begin
        div++;
        if (div == CLK_DIV) begin
          div = 0;
          step_in = 1'b1;
          if (!dir_in) begin
            pos++;
            if (pos == SPAN) dir_in = 1'b1;
          end else begin
            pos--;
            if (pos == 0) begin
              dir_in = 1'b0;
              if (!run) moving = 0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_model_idle(input string name);
    int cyc = 0;
    while (moving && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_model_idle_timeout"}, int'(moving), 0);
  endtask

  task automatic accept_cmd(input int n);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_sweeps = SW'(n);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
  endtask

  typedef struct {
    int sweeps;
    int abort_pulses;   // -1: no abort, else abort after this many sweep pulses
    int abort_dir;      // leg in which abort is raised (0 = L->R, 1 = R->L)
    int exp_sd;
    int exp_aborted;
  } job_t;

  job_t jobs[5];

  task automatic run_job(input job_t j, input int idx);
    int pulses = 0, rises = 0, dones = 0, rise_at_fall = -1, cyc = 0, sd_at_done = -1;
    bit finished = 0, ab_done = 0;
    logic prev_dir, prev_run;
    string tag;
    tag = $sformatf("job%0d", idx);
    accept_cmd(j.sweeps);
    chk({tag, "_run_after_accept"}, int'(run), 1);
    prev_dir = dir_in;
    prev_run = run;
    while (!finished && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
      if (dir_in && !prev_dir) rises++;
      prev_dir = dir_in;
      if (sweep_pulse) pulses++;
      if (prev_run && !run && rise_at_fall < 0) rise_at_fall = rises;
      prev_run = run;
      if (abort && !run) begin
        abort = 1'b0;
        ab_done = 1;
      end
      if (j.abort_pulses >= 0 && !ab_done && pulses == j.abort_pulses &&
          int'(dir_in) == j.abort_dir && pos == 2)
        abort = 1'b1;
      if (done) begin
        dones++;
        finished = 1;
        sd_at_done = int'(sweeps_done);
      end
    end
    abort = 1'b0;
    chk({tag, "_done_timeout"}, int'(finished), 1);
    cyc = 0;
    while ((moving || cyc < 5) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (dir_in && !prev_dir) rises++;
      prev_dir = dir_in;
      if (done) dones++;
    end
    chk({tag, "_sweeps_done_at_done"}, sd_at_done, j.exp_sd);
    chk({tag, "_sweep_pulses"}, pulses, j.exp_sd);
    chk({tag, "_done_count"}, dones, 1);
    chk({tag, "_total_rises"}, rises, j.exp_sd);
    chk({tag, "_aborted"}, int'(aborted), j.exp_aborted);
    chk({tag, "_sweeps_done_held"}, int'(sweeps_done), j.exp_sd);
    if (j.abort_pulses < 0) chk({tag, "_run_fall_rise_idx"}, rise_at_fall, j.sweeps);
  endtask

  initial begin
    int cyc, ready_bad, dn;
    bit fin;

    jobs[0] = '{3, -1, 0, 3, 0};
    jobs[1] = '{5,  1, 0, 2, 1};
    jobs[2] = '{5,  1, 1, 2, 1};
    jobs[3] = '{1, -1, 0, 1, 0};
    jobs[4] = '{4,  0, 0, 1, 1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_run", int'(run), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_sweeps_done", int'(sweeps_done), 0);
    chk("rst_sweep_pulse", int'(sweep_pulse), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_job(jobs[i], i);

    // zero-sweep job: done two cycles after the accept cycle, run never rises
    accept_cmd(0);
    chk("zero_s0_done", int'(done), 0);
    chk("zero_s0_run", int'(run), 0);
    chk("zero_aborted_cleared", int'(aborted), 0);
    @(posedge clk); #1;
    chk("zero_s1_done", int'(done), 1);
    chk("zero_s1_run", int'(run), 0);
    chk("zero_sweeps_done", int'(sweeps_done), 0);
    @(posedge clk); #1;
    chk("zero_s2_done", int'(done), 0);
    chk("zero_s2_ready", int'(cmd_ready), 1);

    // cmd_valid held through a job: ready must stay low until done
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_sweeps = SW'(1);
    ready_bad = 0;
    fin = 0;
    cyc = 0;
    @(posedge clk); #1;
    chk("held_busy_after_accept", int'(busy), 1);
    while (!fin && cyc < 3000) begin
      if (done) begin
        cmd_valid = 1'b0;
        fin = 1;
      end else begin
        if (cmd_ready) ready_bad++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    cmd_valid = 1'b0;
    chk("held_done_seen", int'(fin), 1);
    chk("held_ready_low_cycles", ready_bad, 0);
    chk("held_sweeps_done", int'(sweeps_done), 1);
    wait_model_idle("held");
    chk("held_no_second_job", int'(busy), 0);

    // stall: controller frozen after accept
    freeze = 1;
    accept_cmd(1);
    dn = 0;
`ifdef SCAN_SEQ_WATCHDOG_EN
    for (int k = 1; k < 100; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("wd_error_before_limit", int'(error), 0);
    chk("wd_run_before_limit", int'(run), 1);
    @(posedge clk); #1;
    chk("wd_error_at_limit", int'(error), 1);
    chk("wd_run_at_limit", int'(run), 0);
    chk("wd_busy_in_error", int'(busy), 0);
    chk("wd_ready_in_error", int'(cmd_ready), 0);
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("wd_no_done", dn, 0);
    chk("wd_error_sticky", int'(error), 1);
    @(negedge clk);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk("wd_error_cleared", int'(error), 0);
    chk("wd_ready_after_clear", int'(cmd_ready), 1);
    freeze = 0;
`else
    repeat (150) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("nowd_error_low", int'(error), 0);
    chk("nowd_run_held", int'(run), 1);
    chk("nowd_no_done", dn, 0);
    @(negedge clk);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk("nowd_err_clear_ignored", int'(busy), 1);
    freeze = 0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("nowd_job_completes", int'(done), 1);
    chk("nowd_sweeps_done", int'(sweeps_done), 1);
    wait_model_idle("nowd");
`endif

    // reset in the middle of the second sweep
    accept_cmd(3);
    cyc = 0;
    while (!(sweeps_done == SW'(1) && pos == 2) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midrst_pre_sweeps_done", int'(sweeps_done), 1);
    chk("midrst_pre_run", int'(run), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_run", int'(run), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sweeps_done", int'(sweeps_done), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_after", int'(cmd_ready), 1);
    wait_model_idle("midrst");
    chk("midrst_sweeps_still0", int'(sweeps_done), 0);
    chk("midrst_idle_busy", int'(busy), 0);
    chk("midrst_run_stays0", int'(run), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
